// File: rtl/i2s_mic_rx.sv
// I2S master receiver for a MEMS microphone: generates SCK/WS from clk, deserialises
// MSB-first slots with the standard one-bit delay, and presents samples on a one-deep valid/ready port.
module i2s_mic_rx #(
   parameter int CLK_DIV    = 4,
   parameter int SLOT_W     = 32,
   parameter int SAMPLE_W   = 24,
   parameter bit STEREO     = 1'b0,
   parameter bit LR_CHANNEL = 1'b0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   output logic                mic_lr,
   output logic                mic_ws,
   output logic                mic_sck,
   input  logic                mic_sd,
   output logic [SAMPLE_W-1:0] out_sample,
   output logic                out_ch,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                overrun,
   input  logic                clear_overrun
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int BC_W  = $clog2(2 * SLOT_W);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(2 * SLOT_W - 1);
   localparam logic [BC_W-1:0]  SLOT_BC  = BC_W'(SLOT_W);
   localparam logic [BC_W-1:0]  SMP_BC   = BC_W'(SAMPLE_W);

   logic [DIV_W-1:0]    div_q, div_d;
   logic                sck_q, sck_d;
   logic [BC_W-1:0]     bc_q, bc_d;
   logic                ws_q, ws_d;
   logic [SAMPLE_W-1:0] shift_q, shift_d;
   logic                done_q, done_d;
   logic                done_ch_q, done_ch_d;
   logic [SAMPLE_W-1:0] out_sample_q, out_sample_d;
   logic                out_ch_q, out_ch_d;
   logic                out_valid_q, out_valid_d;
   logic                overrun_q, overrun_d;

   logic                tick, rise, fall, in_window, keep, set_ovr;
   logic [BC_W-1:0]     sb;
   logic [SAMPLE_W:0]   shift_ext;

   assign shift_ext = {shift_q, mic_sd};

   // NOTE: every variable gets its hold value first so no path through this block
   // leaves it unassigned; that is what keeps the combinational logic latch-free.
   always_comb begin
      div_d        = div_q;
      sck_d        = sck_q;
      bc_d         = bc_q;
      ws_d         = ws_q;
      shift_d      = shift_q;
      out_sample_d = out_sample_q;
      out_ch_d     = out_ch_q;
      out_valid_d  = out_valid_q;
      set_ovr      = 1'b0;

      tick      = enable && (div_q == DIV_LAST);
      rise      = tick && !sck_q;
      fall      = tick && sck_q;
      sb        = (bc_q >= SLOT_BC) ? bc_q - SLOT_BC : bc_q;
      in_window = (sb != '0) && (sb <= SMP_BC);
      keep      = STEREO || (ws_q == LR_CHANNEL);

      if (!enable) begin
         div_d   = '0;
         sck_d   = 1'b0;
         bc_d    = '0;
         ws_d    = 1'b0;
         shift_d = '0;
      end else begin
         div_d = tick ? '0 : div_q + DIV_W'(1);
         if (tick) sck_d = !sck_q;
         // WS is derived from the advanced count so it only ever moves on a fall event.
         if (fall) begin
            bc_d = (bc_q == BC_LAST) ? '0 : bc_q + BC_W'(1);
            ws_d = (bc_d >= SLOT_BC);
         end
         if (rise && in_window) shift_d = shift_ext[SAMPLE_W-1:0];
      end

      done_d    = rise && (sb == SMP_BC) && keep;
      done_ch_d = ws_q;

      // A completion is presented one edge later; a same-cycle accept frees the slot for it.
      if (done_q) begin
         if (!out_valid_q || out_ready) begin
            out_sample_d = shift_q;
            out_ch_d     = done_ch_q;
            out_valid_d  = 1'b1;
         end else begin
            set_ovr = 1'b1;
         end
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      if (set_ovr)            overrun_d = 1'b1;
      else if (clear_overrun) overrun_d = 1'b0;
      else                    overrun_d = overrun_q;
   end

   // NOTE: state updates use non-blocking assignments so every register samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q        <= '0;
         sck_q        <= 1'b0;
         bc_q         <= '0;
         ws_q         <= 1'b0;
         shift_q      <= '0;
         done_q       <= 1'b0;
         done_ch_q    <= 1'b0;
         out_sample_q <= '0;
         out_ch_q     <= 1'b0;
         out_valid_q  <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         div_q        <= div_d;
         sck_q        <= sck_d;
         bc_q         <= bc_d;
         ws_q         <= ws_d;
         shift_q      <= shift_d;
         done_q       <= done_d;
         done_ch_q    <= done_ch_d;
         out_sample_q <= out_sample_d;
         out_ch_q     <= out_ch_d;
         out_valid_q  <= out_valid_d;
         overrun_q    <= overrun_d;
      end
   end

   assign mic_lr     = LR_CHANNEL;
   assign mic_ws     = ws_q;
   assign mic_sck    = sck_q;
   assign out_sample = out_sample_q;
   assign out_ch     = out_ch_q;
   assign out_valid  = out_valid_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_i2s_mic_rx.sv
// Bench for i2s_mic_rx: a mono and a stereo receiver share one microphone model; an
// arithmetic frame model predicts pins and outputs every cycle, plus literal spot checks.
module tb_i2s_mic_rx;

   localparam int CD    = 2;
   localparam int SW    = 32;
   localparam int SMW   = 24;
   localparam int FRAME = 2 * SW * 2 * CD;

   logic           clk = 1'b0;
   logic           rst, enable, mic_sd;
   logic [1:0]     ready_v, clr_v;
   logic [1:0]     lr_v, ws_v, sck_v, ch_v, valid_v, ovr_v;
   logic [SMW-1:0] smp_v [2];

   int checks = 0;
   int errors = 0;
   int mode   = 0;

   // Frame model: position is the count of enabled clk edges since enable/reset.
   int             m_n, m_word_id;
   bit             m_have;
   logic [SMW-1:0] m_word [2];
   bit             m_valid [2], m_ovr [2], m_ch [2], m_pend [2], m_pch [2];
   logic [SMW-1:0] m_smp [2], m_pw [2];
   bit             c_rst, c_en;
   bit [1:0]       c_ready, c_clr;

   always #5 clk = ~clk;

   i2s_mic_rx #(.CLK_DIV(CD), .SLOT_W(SW), .SAMPLE_W(SMW), .STEREO(1'b0), .LR_CHANNEL(1'b0)) u_mono (
      .clk(clk), .rst(rst), .enable(enable),
      .mic_lr(lr_v[0]), .mic_ws(ws_v[0]), .mic_sck(sck_v[0]), .mic_sd(mic_sd),
      .out_sample(smp_v[0]), .out_ch(ch_v[0]), .out_valid(valid_v[0]), .out_ready(ready_v[0]),
      .overrun(ovr_v[0]), .clear_overrun(clr_v[0]));

   i2s_mic_rx #(.CLK_DIV(CD), .SLOT_W(SW), .SAMPLE_W(SMW), .STEREO(1'b1), .LR_CHANNEL(1'b0)) u_st (
      .clk(clk), .rst(rst), .enable(enable),
      .mic_lr(lr_v[1]), .mic_ws(ws_v[1]), .mic_sck(sck_v[1]), .mic_sd(mic_sd),
      .out_sample(smp_v[1]), .out_ch(ch_v[1]), .out_valid(valid_v[1]), .out_ready(ready_v[1]),
      .overrun(ovr_v[1]), .clear_overrun(clr_v[1]));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int bc_of(input int n);
      return (n / (2 * CD)) % (2 * SW);
   endfunction

   task automatic m_reset();
      m_n = 0; m_have = 0; m_word_id = 0;
      for (int d = 0; d < 2; d++) begin
         m_valid[d] = 0; m_ovr[d] = 0; m_ch[d] = 0; m_pend[d] = 0;
         m_pch[d] = 0; m_smp[d] = '0; m_pw[d] = '0;
      end
   endtask

   task automatic m_step();
      int bc;
      bit slot;
      for (int d = 0; d < 2; d++) begin
         if (m_pend[d]) begin
            if (!m_valid[d] || c_ready[d]) begin
               m_valid[d] = 1; m_smp[d] = m_pw[d]; m_ch[d] = m_pch[d];
               if (c_clr[d]) m_ovr[d] = 0;
            end else begin
               m_ovr[d] = 1;
            end
         end else begin
            if (m_valid[d] && c_ready[d]) m_valid[d] = 0;
            if (c_clr[d]) m_ovr[d] = 0;
         end
         m_pend[d] = 0;
      end
      if (c_en) begin
         m_n++;
         if (m_n % (2 * CD) == CD) begin
            bc   = bc_of(m_n);
            slot = (bc >= SW);
            if (bc % SW == SMW)
               for (int d = 0; d < 2; d++)
                  if (d == 1 || slot == 1'b0) begin
                     m_pend[d] = 1; m_pw[d] = m_word[slot]; m_pch[d] = slot;
                  end
         end
      end else begin
         m_n = 0; m_have = 0;
      end
   endtask

   // Microphone: fresh word at each slot start, MSB one bit after the WS change.
   task automatic mic_drive();
      int  bc, sb, id;
      bit  slot;
      bc   = bc_of(m_n);
      sb   = bc % SW;
      slot = (bc >= SW);
      id   = m_n / (2 * CD * SW);
      if (!m_have || id != m_word_id) begin
         m_have = 1; m_word_id = id;
         case (mode)
            1:       m_word[slot] = slot ? 24'h123456 : 24'hA5A5A5;
            2:       m_word[slot] = slot ? 24'h7FFFFF : 24'h800001;
            default: m_word[slot] = SMW'($urandom);
         endcase
      end
      if (sb >= 1 && sb <= SMW) mic_sd = m_word[slot][SMW-sb];
      else                      mic_sd = 1'($urandom_range(0, 1));
   endtask

   initial begin
      mic_sd = 1'b0;
      m_reset();
      forever begin
         @(posedge clk);
         c_rst = rst; c_en = enable; c_ready = ready_v; c_clr = clr_v;
         @(negedge clk);
         if (rst || c_rst) m_reset();
         else              m_step();
         mic_drive();
         for (int d = 0; d < 2; d++) begin
            check($sformatf("sck%0d", d), 32'(sck_v[d]), 32'((m_n / CD) % 2));
            check($sformatf("ws%0d", d), 32'(ws_v[d]), 32'(bc_of(m_n) >= SW));
            check($sformatf("lr%0d", d), 32'(lr_v[d]), 32'd0);
            check($sformatf("valid%0d", d), 32'(valid_v[d]), 32'(m_valid[d]));
            check($sformatf("overrun%0d", d), 32'(ovr_v[d]), 32'(m_ovr[d]));
            check($sformatf("sample%0d", d), 32'(smp_v[d]), 32'(m_smp[d]));
            check($sformatf("ch%0d", d), 32'(ch_v[d]), 32'(m_ch[d]));
         end
      end
   end

   task automatic measure_period(input bit sel_ws, input int budget, output int period);
      int   t0;
      logic p, c;
      t0 = -1; period = -1;
      p = sel_ws ? ws_v[1] : sck_v[1];
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         c = sel_ws ? ws_v[1] : sck_v[1];
         if (!p && c) begin
            if (t0 < 0) t0 = i;
            else begin period = i - t0; break; end
         end
         p = c;
      end
   endtask

   task automatic timeout(input string name);
      checks++; errors++;
      $display("FAIL %s timed out at %0t", name, $time);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   int             period, nm, ns, cnt, off_cnt;
   bit             found;
   logic           prev_sck, prev_ws;
   logic [SMW-1:0] got_s [4];
   logic           got_c [4];

   initial begin
      rst = 1'b1; enable = 1'b0; ready_v = 2'b11; clr_v = 2'b00; mode = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0; enable = 1'b1; ready_v = 2'b00;

      // Async reset mid left slot at bit 10 while SCK is high and both outputs are backed up.
      repeat (3 * FRAME) @(posedge clk);
      found = 0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         @(negedge clk); #1;
         if (bc_of(m_n) == 10 && (m_n / CD) % 2 == 1) begin found = 1; break; end
      end
      if (!found) timeout("wait_bit10");
      for (int d = 0; d < 2; d++) begin
         check($sformatf("pre_rst_sck%0d", d), 32'(sck_v[d]), 32'd1);
         check($sformatf("pre_rst_valid%0d", d), 32'(valid_v[d]), 32'd1);
         check($sformatf("pre_rst_ovr%0d", d), 32'(ovr_v[d]), 32'd1);
      end
      rst = 1'b1;
      #1;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("async_sck%0d", d), 32'(sck_v[d]), 32'd0);
         check($sformatf("async_ws%0d", d), 32'(ws_v[d]), 32'd0);
         check($sformatf("async_valid%0d", d), 32'(valid_v[d]), 32'd0);
         check($sformatf("async_ovr%0d", d), 32'(ovr_v[d]), 32'd0);
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      measure_period(1'b0, 20, period);
      check("sck_period", 32'(period), 32'(2 * CD));
      measure_period(1'b1, 3 * FRAME, period);
      check("ws_period", 32'(period), 32'(FRAME));

      // WS may only move together with an SCK fall.
      prev_sck = sck_v[1]; prev_ws = ws_v[1]; cnt = 0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         @(negedge clk);
         if (ws_v[1] !== prev_ws) begin
            cnt++;
            check("ws_on_fall", 32'({prev_sck, sck_v[1]}), 32'd2);
         end
         prev_sck = sck_v[1]; prev_ws = ws_v[1];
      end
      check("ws_toggles", 32'(cnt), 32'd4);

      // Mono keeps only the left slot: one output per frame.
      @(posedge clk); #1 mode = 1; ready_v = 2'b11;
      repeat (2 * FRAME) @(posedge clk);
      nm = 0; ns = 0;
      for (int i = 0; i < 4 * FRAME; i++) begin
         @(negedge clk);
         if (valid_v[0]) begin
            nm++;
            check("mono_sample", 32'(smp_v[0]), 32'h00A5A5A5);
            check("mono_ch", 32'(ch_v[0]), 32'd0);
         end
         if (valid_v[1]) ns++;
      end
      check("mono_count", 32'(nm), 32'd4);
      check("stereo_count", 32'(ns), 32'd8);

      // Stereo alternates left/right with the extreme patterns.
      @(posedge clk); #1 mode = 2;
      repeat (2 * FRAME) @(posedge clk);
      cnt = 0;
      for (int i = 0; i < 2 * FRAME && cnt < 4; i++) begin
         @(negedge clk);
         if (valid_v[1]) begin got_s[cnt] = smp_v[1]; got_c[cnt] = ch_v[1]; cnt++; end
      end
      check("stereo_collect", 32'(cnt), 32'd4);
      for (int i = 0; i < cnt; i++) begin
         check("stereo_value", 32'(got_s[i]), got_c[i] ? 32'h007FFFFF : 32'h00800001);
         if (i > 0) check("stereo_alternate", 32'(got_c[i] ^ got_c[i-1]), 32'd1);
      end

      // Backpressure for two frames from a fresh left-slot start.
      @(posedge clk); #1 enable = 1'b0;
      repeat (4) @(posedge clk);
      #1 ready_v = 2'b00; clr_v = 2'b11;
      @(posedge clk); #1 clr_v = 2'b00; enable = 1'b1;
      repeat (540) @(posedge clk);
      @(negedge clk);
      check("bp_valid", 32'(valid_v[1]), 32'd1);
      check("bp_held_sample", 32'(smp_v[1]), 32'h00800001);
      check("bp_held_ch", 32'(ch_v[1]), 32'd0);
      check("bp_overrun", 32'(ovr_v[1]), 32'd1);
      #1 ready_v = 2'b11;
      @(posedge clk); #1 ready_v = 2'b00;
      @(negedge clk);
      check("bp_accepted", 32'(valid_v[1]), 32'd0);
      check("bp_ovr_sticky", 32'(ovr_v[1]), 32'd1);
      #1 clr_v = 2'b11;
      @(posedge clk); #1 clr_v = 2'b00;
      @(negedge clk);
      check("clear_ovr_st", 32'(ovr_v[1]), 32'd0);
      check("clear_ovr_mono", 32'(ovr_v[0]), 32'd0);

      // Accept lands on the very cycle the next sample is loaded.
      #1 ready_v = 2'b11;
      @(posedge clk); #1 enable = 1'b0;
      repeat (4) @(posedge clk);
      #1 ready_v[1] = 1'b0; enable = 1'b1;
      found = 0;
      for (int i = 0; i < FRAME + 200; i++) begin
         @(negedge clk); #1;
         if (m_pend[1] && m_valid[1]) begin found = 1; break; end
      end
      if (!found) timeout("wait_coincident");
      ready_v[1] = 1'b1;
      @(posedge clk); #1 ready_v[1] = 1'b0;
      @(negedge clk);
      check("coin_valid", 32'(valid_v[1]), 32'd1);
      check("coin_ovr", 32'(ovr_v[1]), 32'd0);
      check("coin_ch", 32'(ch_v[1]), 32'd1);
      check("coin_sample", 32'(smp_v[1]), 32'h007FFFFF);

      // Drop enable at slot bit 12 of the right slot; restart must begin on the left.
      #1 ready_v = 2'b11;
      found = 0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         @(negedge clk); #1;
         if (bc_of(m_n) == SW + 12) begin found = 1; break; end
      end
      if (!found) timeout("wait_right_bit12");
      enable = 1'b0;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (valid_v[1]) cnt++;
      end
      check("drop_no_output", 32'(cnt), 32'd0);
      @(posedge clk); #1 enable = 1'b1;
      found = 0;
      for (int i = 0; i < FRAME; i++) begin
         @(negedge clk);
         if (valid_v[1]) begin found = 1; break; end
      end
      check("restart_found", 32'(found), 32'd1);
      check("restart_ch", 32'(ch_v[1]), 32'd0);
      check("restart_sample", 32'(smp_v[1]), 32'h00800001);

      // Random data, consumer timing, overrun clears and enable drops.
      @(posedge clk); #1 mode = 0;
      off_cnt = 0;
      for (int i = 0; i < 12000; i++) begin
         @(posedge clk); #1;
         ready_v = {($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 7)};
         clr_v   = {($urandom_range(0, 29) == 0), ($urandom_range(0, 29) == 0)};
         if (off_cnt > 0) begin
            off_cnt--;
            if (off_cnt == 0) enable = 1'b1;
         end else if ($urandom_range(0, 2999) == 0) begin
            enable  = 1'b0;
            off_cnt = $urandom_range(5, 60);
         end
      end
      enable = 1'b1;
      repeat (4) @(posedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
